// File: rtl/mmix_mem_bridge.sv
// MMIX 64-bit load/store to 16-bit big-endian req/ack external memory bridge.
// Optional per-beat ack timeout: define MMIX_MEM_BRIDGE_TIMEOUT_EN.
module mmix_mem_bridge #(
  parameter int AW      = 22,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   mem_address,
  input  logic [1:0]    mem_datasize,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [63:0]   mem_writedata,
  output logic [63:0]   mem_readdata,
  output logic          mem_done,
  output logic          bus_err,
  output logic [AW-1:0] ext_addr,
  output logic [15:0]   ext_wdata,
  output logic [1:0]    ext_be,
  output logic          ext_we,
  output logic          ext_req,
  input  logic [15:0]   ext_rdata,
  input  logic          ext_ack
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  state_t state, state_nxt;

  logic          we_q;
  logic [1:0]    size_q, left_q, be_q;
  logic [63:0]   wsh_q, acc_q, acc_nxt, wsh_init;
  logic [AW-1:0] addr_q, base;
  logic [1:0]    nbeats_m1;
  logic          start, last_ack, tmo;
  logic [AW:0]   win;
  logic          unused_bits;

  function automatic logic [63:0] size_mask(input logic [1:0] sz, input logic [63:0] v);
    case (sz)
      2'd0:    size_mask = {56'h0, v[7:0]};
      2'd1:    size_mask = {48'h0, v[15:0]};
      2'd2:    size_mask = {32'h0, v[31:0]};
      default: size_mask = v;
    endcase
  endfunction

  // Address bits above the window are dropped, so accesses alias modulo 2^(AW+1) bytes.
  assign win         = mem_address[AW:0];
  assign unused_bits = ^mem_address[63:AW+1];
  assign start       = (state == IDLE) && (mem_read || mem_write);
  assign last_ack    = (state == BEAT) && ext_ack && (left_q == 2'd0);

  always_comb begin
    base      = win[AW:1];
    nbeats_m1 = 2'd0;
    wsh_init  = {mem_writedata[7:0], 56'h0};
    case (mem_datasize)
      2'd1: wsh_init = {mem_writedata[15:0], 48'h0};
      2'd2: begin
        base      = {win[AW:2], 1'b0};
        nbeats_m1 = 2'd1;
        wsh_init  = {mem_writedata[31:0], 32'h0};
      end
      2'd3: begin
        base      = {win[AW:3], 2'b00};
        nbeats_m1 = 2'd3;
        wsh_init  = mem_writedata;
      end
      default: ;
    endcase
  end

  // Byte reads take only the enabled lane; wider reads shift in a whole word per beat.
  assign acc_nxt = (size_q == 2'd0)
                 ? {acc_q[55:0], (be_q[1] ? ext_rdata[15:8] : ext_rdata[7:0])}
                 : {acc_q[47:0], ext_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_read || mem_write) state_nxt = BEAT;
      BEAT:    if (last_ack || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      left_q       <= 2'd0;
      be_q         <= 2'd0;
      wsh_q        <= '0;
      acc_q        <= '0;
      addr_q       <= '0;
      mem_readdata <= '0;
    end else if (start) begin
      we_q   <= mem_write;
      size_q <= mem_datasize;
      addr_q <= base;
      left_q <= nbeats_m1;
      be_q   <= (mem_datasize != 2'd0) ? 2'b11 : (mem_address[0] ? 2'b01 : 2'b10);
      wsh_q  <= wsh_init;
      acc_q  <= '0;
    end else if (state == BEAT) begin
      if (ext_ack) begin
        acc_q <= acc_nxt;
        if (left_q == 2'd0) begin
          if (!we_q) mem_readdata <= size_mask(size_q, acc_nxt);
        end else begin
          addr_q <= addr_q + 1'b1;
          left_q <= left_q - 2'd1;
          wsh_q  <= {wsh_q[47:0], 16'h0};
        end
      end else if (tmo && !we_q) begin
        mem_readdata <= size_mask(size_q, {64{1'b1}});
      end
    end
  end

  assign ext_req   = (state == BEAT);
  assign mem_done  = (state == DONE);
  assign ext_addr  = addr_q;
  assign ext_we    = we_q;
  assign ext_be    = be_q;
  assign ext_wdata = (size_q == 2'd0) ? {2{wsh_q[63:56]}} : wsh_q[63:48];

`ifdef MMIX_MEM_BRIDGE_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q;
  logic          err_q;

  // Fires on the TIMEOUT-th consecutive un-acked BEAT cycle; an ack that cycle wins.
  assign tmo     = (state == BEAT) && !ext_ack && (cnt_q == TW'(TIMEOUT - 1));
  assign bus_err = err_q && (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != BEAT || ext_ack) cnt_q <= '0;
      else                          cnt_q <= cnt_q + 1'b1;
      if (state == IDLE) err_q <= 1'b0;
      else if (tmo)      err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign tmo        = 1'b0;
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Bench for mmix_mem_bridge: word-memory responder, spec-level access model, per-cycle compare.
module tb_mmix_mem_bridge;
  localparam int AW  = 22;
  localparam int TMO = 16;

  logic          clk = 1'b0, reset = 1'b1;
  logic [63:0]   mem_address = '0, mem_writedata = '0, mem_readdata;
  logic [1:0]    mem_datasize = '0;
  logic          mem_read = 1'b0, mem_write = 1'b0, mem_done, bus_err;
  logic [AW-1:0] ext_addr;
  logic [15:0]   ext_wdata, ext_rdata = 16'h0BAD;
  logic [1:0]    ext_be;
  logic          ext_we, ext_req, ext_ack = 1'b0;

  mmix_mem_bridge #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_datasize(mem_datasize),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done), .bus_err(bus_err),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_we(ext_we),
    .ext_req(ext_req), .ext_rdata(ext_rdata), .ext_ack(ext_ack));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [1:0]    be;
    logic          we;
    logic [15:0]   wd;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] alog[$];
  logic [15:0]   ram [int unsigned];
  int            compared = 0, mismatched = 0;
  int            delay = 0, wcnt = 0, cyc = 0, done_cnt = 0, lat;
  bit            exp_done = 0, exp_err = 0, req_p = 0, ack_p = 0;
  logic [63:0]   exp_rd, last_rd = '0;
  beat_t         cur, fld_p, e;

  function automatic logic [15:0] rd_ram(input int unsigned w);
    return ram.exists(w) ? ram[w] : 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Responder plus the single compare process.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      ext_ack = 1'b0; wcnt = 0; req_p = 0; ack_p = 0;
    end else begin
      cur = '{a: ext_addr, be: ext_be, we: ext_we, wd: ext_wdata};
      if (req_p && !ack_p && ext_req) chk("hold_fields", 64'(cur), 64'(fld_p));
      if (ext_req) begin
        if (wcnt >= delay) begin ext_ack = 1'b1; wcnt = 0; end
        else begin ext_ack = 1'b0; wcnt++; end
      end else begin
        ext_ack = cyc[0];   // stray acks outside a beat must be ignored
        wcnt = 0;
      end
      ext_rdata = (ext_ack && ext_req) ? rd_ram(32'(ext_addr)) : 16'h0BAD;
      if (ext_ack && ext_req) begin
        if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("beat_addr", 64'(ext_addr), 64'(e.a));
          chk("beat_be", 64'(ext_be), 64'(e.be));
          chk("beat_we", 64'(ext_we), 64'(e.we));
          if (e.we) chk("beat_wdata", 64'(ext_wdata), 64'(e.wd));
        end
        alog.push_back(ext_addr);
        if (ext_we) begin
          logic [15:0] t;
          t = rd_ram(32'(ext_addr));
          if (ext_be[1]) t[15:8] = ext_wdata[15:8];
          if (ext_be[0]) t[7:0]  = ext_wdata[7:0];
          ram[32'(ext_addr)] = t;
        end
      end
      if (mem_done) begin
        chk("done_expected", 64'(mem_done), 64'(exp_done));
        if (exp_done) begin
          chk("readdata", mem_readdata, exp_rd);
          chk("bus_err", 64'(bus_err), 64'(exp_err));
          if (exp_err) exp_q.delete();
          else chk("beats_left", 64'(exp_q.size()), 64'd0);
        end
        exp_done = 0;
        done_cnt++;
      end else if (bus_err) chk("bus_err_idle", 64'(bus_err), 64'd0);
      req_p = ext_req;
      ack_p = ext_ack && ext_req;
      fld_p = cur;
    end
  end

  // Spec-level model: expected beat list and read result from memory contents.
  task automatic plan(input bit wr, input logic [63:0] a, input logic [1:0] sz,
                      input logic [63:0] wd, input bit tmo);
    int nb, nw;
    int unsigned ab, w;
    logic [63:0] al, v;
    logic [15:0] t;
    beat_t b;
    nb = 1 << sz;
    al = (sz == 2'd0) ? a : (a & ~(64'(nb) - 64'd1));
    ab = 32'(al[AW:0]);
    nw = (sz == 2'd0) ? 1 : nb / 2;
    v  = '0;
    for (int k = 0; k < nw; k++) begin
      w    = ((ab >> 1) + 32'(k)) & ((32'd1 << AW) - 1);
      b.a  = AW'(w);
      b.be = (sz != 2'd0) ? 2'b11 : (ab[0] ? 2'b01 : 2'b10);
      b.we = wr;
      b.wd = (sz == 2'd0) ? {2{wd[7:0]}} : 16'(wd >> (16 * (nw - 1 - k)));
      exp_q.push_back(b);
      t = rd_ram(w);
      v = (sz == 2'd0) ? {56'h0, (ab[0] ? t[7:0] : t[15:8])} : ((v << 16) | 64'(t));
    end
    if (tmo) v = (sz == 2'd3) ? '1 : ((64'd1 << (8 << sz)) - 64'd1);
    exp_rd   = wr ? last_rd : v;
    exp_err  = tmo;
    exp_done = 1;
  endtask

  // Called at posedge+1; returns the cycle number (request cycle = 1) of mem_done.
  task automatic access(input bit rd, input bit wr, input logic [63:0] a, input logic [1:0] sz,
                        input logic [63:0] wd, input int dly, input bit tmo, output int l);
    plan(wr, a, sz, wd, tmo);
    delay = dly;
    alog.delete();
    mem_read = rd; mem_write = wr; mem_address = a; mem_datasize = sz; mem_writedata = wd;
    l = 0;
    while (1) begin
      @(posedge clk); #1;
      l++;
      if (mem_done) break;
      if (l >= 60) begin chk("done_wait_expired", 64'd0, 64'd1); break; end
    end
    l++;
    if (!wr) last_rd = exp_rd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("req_async_drop", 64'(ext_req), 64'd0);
    chk("done_in_reset", 64'(mem_done), 64'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    exp_q.delete(); exp_done = 0; last_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    #3;
    chk("rst_done", 64'(mem_done), 64'd0);
    chk("rst_err", 64'(bus_err), 64'd0);
    chk("rst_req", 64'(ext_req), 64'd0);
    chk("rst_we", 64'(ext_we), 64'd0);
    chk("rst_be", 64'(ext_be), 64'd0);
    chk("rst_addr", 64'(ext_addr), 64'd0);
    chk("rst_wdata", 64'(ext_wdata), 64'd0);
    chk("rst_rdata", mem_readdata, 64'd0);
    ram[32'h80] = 16'h0123; ram[32'h81] = 16'h4567; ram[32'h82] = 16'h89AB; ram[32'h83] = 16'hCDEF;
    ram[0] = 16'hDEAD; ram[1] = 16'hBEEF; ram[32'h3FFFFE] = 16'hCAFE;
    @(posedge clk); #1;
    reset = 1'b0;

    access(1, 0, 64'h8000_0000_0000_0106, 2'd3, '0, 0, 0, lat);
    chk("octa_lat", 64'(lat), 64'd6);
    chk("octa_val", mem_readdata, 64'h0123_4567_89AB_CDEF);
    chk("octa_a0", 64'(alog[0]), 64'h80);
    chk("octa_a3", 64'(alog[3]), 64'h83);

    access(1, 0, 64'h0000_0000_0000_0002, 2'd2, '0, 3, 0, lat);
    chk("tetra_lat", 64'(lat), 64'd10);
    chk("tetra_val", mem_readdata, 64'h0000_0000_DEAD_BEEF);
    chk("tetra_a1", 64'(alog[1]), 64'h1);

    access(0, 1, 64'h0000_0000_0000_0003, 2'd0, 64'hFFFF_FFFF_FFFF_FF5A, 0, 0, lat);
    chk("byte_lat", 64'(lat), 64'd3);
    chk("byte_ram", 64'(rd_ram(1)), 64'hBE5A);
    chk("wr_keeps_rdata", mem_readdata, 64'h0000_0000_DEAD_BEEF);

    access(1, 1, 64'h0000_0000_0000_0200, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 1, 0, lat);
    chk("both_is_write", 64'(rd_ram(32'h100)), 64'hBEEF);

    access(0, 1, 64'hFFFF_FFFF_FF7F_FFFE, 2'd1, 64'h1234, 0, 0, lat);
    chk("wrap_wyde_a", 64'(alog[0]), 64'h3FFFFF);
    access(1, 0, 64'h0000_0000_007F_FFFE, 2'd2, '0, 0, 0, lat);
    chk("wrap_tetra_a0", 64'(alog[0]), 64'h3FFFFE);
    chk("wrap_tetra_val", mem_readdata, 64'h0000_0000_CAFE_1234);
    access(1, 0, 64'h0123_0000_00FF_FFFE, 2'd1, '0, 0, 0, lat);
    chk("alias_val", mem_readdata, 64'h1234);

    // Abort an octa read while its third beat is outstanding.
    plan(0, 64'h100, 2'd3, '0, 0);
    delay = 0; alog.delete(); dc = done_cnt;
    mem_read = 1'b1; mem_address = 64'h100; mem_datasize = 2'd3;
    for (int i = 0; i < 20 && alog.size() < 2; i++) begin @(posedge clk); #1; end
    chk("abort_in_beat", 64'(ext_req), 64'd1);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    access(1, 0, 64'h0000_0000_0000_0107, 2'd0, '0, 0, 0, lat);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_val", mem_readdata, 64'hEF);

`ifdef MMIX_MEM_BRIDGE_TIMEOUT_EN
    access(1, 0, 64'h0, 2'd2, '0, 100000, 1, lat);
    chk("tmo_lat", 64'(lat), 64'(TMO + 2));
    chk("tmo_val", mem_readdata, 64'h0000_0000_FFFF_FFFF);
`else
    plan(0, 64'h0, 2'd2, '0, 0);
    exp_done = 0; delay = 100000; dc = done_cnt;
    mem_read = 1'b1; mem_address = 64'h0; mem_datasize = 2'd2;
    repeat (1000) @(posedge clk);
    #1;
    chk("hang_req", 64'(ext_req), 64'd1);
    chk("hang_no_done", 64'(done_cnt), 64'(dc));
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
